// File: rtl/pipe_ctrl_decoder.sv
// Registered ID/EX control decoder for the redirecting MIPS pipeline, with bubble
// insertion and a SYSCALL halt sequencer. Optional statistics counters: CTRL_STATS_EN.
module pipe_ctrl_decoder #(
  parameter int ALU_OP_W     = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [5:0]          OP,
  input  logic [5:0]          Func,
  input  logic                ID_Valid,
  input  logic                Stall,
  input  logic                Flush,
  input  logic                SysArgHalt,
  output logic                EX_Valid,
  output logic [ALU_OP_W-1:0] EX_ALU_OP,
  output logic                EX_ALU_SRC,
  output logic                EX_RegWrite,
  output logic                EX_MemToReg,
  output logic                EX_MemWrite,
  output logic                EX_RegDst,
  output logic                EX_SignedExt,
  output logic                EX_HalfW,
  output logic                EX_Vshamt,
  output logic                EX_Beq,
  output logic                EX_Bne,
  output logic                EX_BLEZ,
  output logic                EX_JMP,
  output logic                EX_JAL,
  output logic                EX_JR,
  output logic                EX_SysCALL,
  output logic                EX_Illegal,
  output logic                FetchEn,
  output logic                Halted
`ifdef CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]    DecCnt,
  output logic [CNT_W-1:0]    BubbleCnt
`endif
);

  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(11);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(12);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  typedef struct packed {
    logic [ALU_OP_W-1:0] aluOp;
    logic                aluSrc;
    logic                regWrite;
    logic                memToReg;
    logic                memWrite;
    logic                regDst;
    logic                signedExt;
    logic                halfW;
    logic                vshamt;
    logic                beq;
    logic                bne;
    logic                blez;
    logic                jmp;
    logic                jal;
    logic                jr;
    logic                sysCall;
    logic                illegal;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t     state_q, state_d;
  logic [3:0] drainCnt_q, drainCnt_d;
  ctrl_t      exCtrl_q, exCtrl_d;
  logic       exValid_q, exValid_d;
  ctrl_t      dec;
  logic       accept;
  logic       haltReq;

  // Pure decode of the instruction currently in ID.
  always_comb begin
    dec = '0;
    case (OP)
      6'h00: begin
        dec.regWrite = 1'b1;
        dec.regDst   = 1'b1;
        case (Func)
          6'h20, 6'h21: dec.aluOp = ALU_ADD;
          6'h22, 6'h23: dec.aluOp = ALU_SUB;
          6'h24:        dec.aluOp = ALU_AND;
          6'h25:        dec.aluOp = ALU_OR;
          6'h26:        dec.aluOp = ALU_XOR;
          6'h27:        dec.aluOp = ALU_NOR;
          6'h2A:        dec.aluOp = ALU_SLT;
          6'h2B:        dec.aluOp = ALU_SLTU;
          6'h00: begin dec.aluOp = ALU_SLL; dec.vshamt = 1'b1; end
          6'h02: begin dec.aluOp = ALU_SRL; dec.vshamt = 1'b1; end
          6'h03: begin dec.aluOp = ALU_SRA; dec.vshamt = 1'b1; end
          6'h04:        dec.aluOp = ALU_SLL;
          6'h06:        dec.aluOp = ALU_SRL;
          6'h07:        dec.aluOp = ALU_SRA;
          6'h08: begin
            dec.regWrite = 1'b0;
            dec.regDst   = 1'b0;
            dec.jr       = 1'b1;
          end
          6'h0C: begin
            dec.regWrite = 1'b0;
            dec.regDst   = 1'b0;
            dec.sysCall  = 1'b1;
          end
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09: begin
        dec.aluOp = ALU_ADD; dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.signedExt = 1'b1;
      end
      6'h0A: begin
        dec.aluOp = ALU_SLT; dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.signedExt = 1'b1;
      end
      6'h0B: begin
        dec.aluOp = ALU_SLTU; dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.signedExt = 1'b1;
      end
      6'h0C: begin dec.aluOp = ALU_AND; dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      6'h0D: begin dec.aluOp = ALU_OR;  dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      6'h0E: begin dec.aluOp = ALU_XOR; dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      6'h23, 6'h21: begin
        dec.aluOp     = ALU_ADD;
        dec.signedExt = 1'b1;
        dec.aluSrc    = 1'b1;
        dec.memToReg  = 1'b1;
        dec.regWrite  = 1'b1;
        dec.halfW     = (OP == 6'h21);
      end
      6'h2B: begin
        dec.aluOp = ALU_ADD; dec.signedExt = 1'b1; dec.aluSrc = 1'b1; dec.memWrite = 1'b1;
      end
      6'h04: begin dec.aluOp = ALU_SUB; dec.signedExt = 1'b1; dec.beq  = 1'b1; end
      6'h05: begin dec.aluOp = ALU_SUB; dec.signedExt = 1'b1; dec.bne  = 1'b1; end
      6'h06: begin dec.aluOp = ALU_SUB; dec.signedExt = 1'b1; dec.blez = 1'b1; end
      6'h02: dec.jmp = 1'b1;
      6'h03: begin dec.jmp = 1'b1; dec.jal = 1'b1; dec.regWrite = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Flush is already excluded here, so it wins over a same-cycle halting SYSCALL.
  assign accept  = ID_Valid & ~Stall & ~Flush & (state_q == RUN);
  assign haltReq = accept & dec.sysCall & SysArgHalt;

  always_comb begin
    exCtrl_d  = accept ? dec : '0;
    exValid_d = accept;
  end

  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    case (state_q)
      RUN: begin
        if (haltReq) begin
          state_d    = DRAIN;
          drainCnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drainCnt_q <= 4'd1) begin
          state_d    = HALT;
          drainCnt_d = 4'd0;
        end else begin
          drainCnt_d = drainCnt_q - 4'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      drainCnt_q <= 4'd0;
      exCtrl_q   <= '0;
      exValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      exCtrl_q   <= exCtrl_d;
      exValid_q  <= exValid_d;
    end
  end

  assign EX_Valid     = exValid_q;
  assign EX_ALU_OP    = exCtrl_q.aluOp;
  assign EX_ALU_SRC   = exCtrl_q.aluSrc;
  assign EX_RegWrite  = exCtrl_q.regWrite;
  assign EX_MemToReg  = exCtrl_q.memToReg;
  assign EX_MemWrite  = exCtrl_q.memWrite;
  assign EX_RegDst    = exCtrl_q.regDst;
  assign EX_SignedExt = exCtrl_q.signedExt;
  assign EX_HalfW     = exCtrl_q.halfW;
  assign EX_Vshamt    = exCtrl_q.vshamt;
  assign EX_Beq       = exCtrl_q.beq;
  assign EX_Bne       = exCtrl_q.bne;
  assign EX_BLEZ      = exCtrl_q.blez;
  assign EX_JMP       = exCtrl_q.jmp;
  assign EX_JAL       = exCtrl_q.jal;
  assign EX_JR        = exCtrl_q.jr;
  assign EX_SysCALL   = exCtrl_q.sysCall;
  assign EX_Illegal   = exCtrl_q.illegal;

  assign FetchEn = (state_q == RUN) & ~Stall;
  assign Halted  = (state_q == HALT);

`ifdef CTRL_STATS_EN
  logic [CNT_W-1:0] decCnt_q, bubbleCnt_q;

  // Bubbles are only counted while running; drain cycles are not pipeline bubbles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      decCnt_q    <= '0;
      bubbleCnt_q <= '0;
    end else begin
      if (accept) begin
        decCnt_q <= decCnt_q + 1'b1;
      end
      if (!accept && state_q == RUN) begin
        bubbleCnt_q <= bubbleCnt_q + 1'b1;
      end
    end
  end

  assign DecCnt    = decCnt_q;
  assign BubbleCnt = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Self-checking bench for pipe_ctrl_decoder: a mnemonic-level reference model checked
// every cycle, plus directed literal expectations. Counter checks need CTRL_STATS_EN.
module tb_pipe_ctrl_decoder;

  localparam int ALU_OP_W = 4;
  localparam int DRAIN    = 3;
  localparam int TB_CNT_W = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic [5:0]          OP;
  logic [5:0]          Func;
  logic                ID_Valid;
  logic                Stall;
  logic                Flush;
  logic                SysArgHalt;
  logic                EX_Valid;
  logic [ALU_OP_W-1:0] EX_ALU_OP;
  logic EX_ALU_SRC, EX_RegWrite, EX_MemToReg, EX_MemWrite, EX_RegDst, EX_SignedExt;
  logic EX_HalfW, EX_Vshamt, EX_Beq, EX_Bne, EX_BLEZ, EX_JMP, EX_JAL, EX_JR;
  logic EX_SysCALL, EX_Illegal, FetchEn, Halted;
`ifdef CTRL_STATS_EN
  logic [TB_CNT_W-1:0] DecCnt, BubbleCnt;
`endif

  always #5 CLK = ~CLK;

  pipe_ctrl_decoder #(
    .ALU_OP_W(ALU_OP_W), .DRAIN_CYCLES(DRAIN), .CNT_W(TB_CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .OP(OP), .Func(Func), .ID_Valid(ID_Valid), .Stall(Stall),
    .Flush(Flush), .SysArgHalt(SysArgHalt), .EX_Valid(EX_Valid), .EX_ALU_OP(EX_ALU_OP),
    .EX_ALU_SRC(EX_ALU_SRC), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_MemWrite(EX_MemWrite), .EX_RegDst(EX_RegDst), .EX_SignedExt(EX_SignedExt),
    .EX_HalfW(EX_HalfW), .EX_Vshamt(EX_Vshamt), .EX_Beq(EX_Beq), .EX_Bne(EX_Bne),
    .EX_BLEZ(EX_BLEZ), .EX_JMP(EX_JMP), .EX_JAL(EX_JAL), .EX_JR(EX_JR),
    .EX_SysCALL(EX_SysCALL), .EX_Illegal(EX_Illegal), .FetchEn(FetchEn), .Halted(Halted)
`ifdef CTRL_STATS_EN
    , .DecCnt(DecCnt), .BubbleCnt(BubbleCnt)
`endif
  );

  // Bundle layout: aluOp[19:16] aluSrc regWrite memToReg memWrite regDst signedExt
  // halfW vshamt beq bne blez jmp jal jr sysCall illegal[0]
  logic [19:0] dutVec;
  assign dutVec = {EX_ALU_OP, EX_ALU_SRC, EX_RegWrite, EX_MemToReg, EX_MemWrite, EX_RegDst,
                   EX_SignedExt, EX_HalfW, EX_Vshamt, EX_Beq, EX_Bne, EX_BLEZ, EX_JMP,
                   EX_JAL, EX_JR, EX_SysCALL, EX_Illegal};

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic string mnemonic(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return "add";
        6'h22, 6'h23: return "sub";
        6'h24: return "and";
        6'h25: return "or";
        6'h26: return "xor";
        6'h27: return "nor";
        6'h2A: return "slt";
        6'h2B: return "sltu";
        6'h00: return "sll";
        6'h02: return "srl";
        6'h03: return "sra";
        6'h04: return "sllv";
        6'h06: return "srlv";
        6'h07: return "srav";
        6'h08: return "jr";
        6'h0C: return "syscall";
        default: return "ill";
      endcase
    end
    case (op)
      6'h08, 6'h09: return "addi";
      6'h0A: return "slti";
      6'h0B: return "sltiu";
      6'h0C: return "andi";
      6'h0D: return "ori";
      6'h0E: return "xori";
      6'h23: return "lw";
      6'h21: return "lh";
      6'h2B: return "sw";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h06: return "blez";
      6'h02: return "j";
      6'h03: return "jal";
      default: return "ill";
    endcase
  endfunction

  function automatic logic [19:0] modelBundle(input logic [5:0] op, input logic [5:0] fn);
    string m = mnemonic(op, fn);
    logic [3:0] alu = 4'd0;
    logic aSrc = 0, rw = 0, m2r = 0, mw = 0, rd = 0, se = 0, hw = 0, vs = 0;
    logic bq = 0, bn = 0, bl = 0, jp = 0, jl = 0, jreg = 0, sc = 0, il = 0;
    case (m)
      "add", "addi", "lw", "lh", "sw": alu = 4'd5;
      "sub", "beq", "bne", "blez":     alu = 4'd6;
      "and", "andi":                   alu = 4'd7;
      "or", "ori":                     alu = 4'd8;
      "xor", "xori":                   alu = 4'd9;
      "nor":                           alu = 4'd10;
      "slt", "slti":                   alu = 4'd11;
      "sltu", "sltiu":                 alu = 4'd12;
      "srl", "srlv":                   alu = 4'd2;
      "sra", "srav":                   alu = 4'd1;
      default:                         alu = 4'd0;
    endcase
    case (m)
      "add", "sub", "and", "or", "xor", "nor", "slt", "sltu", "sllv", "srlv", "srav":
        begin rw = 1; rd = 1; end
      "sll", "srl", "sra":   begin rw = 1; rd = 1; vs = 1; end
      "addi", "slti", "sltiu": begin aSrc = 1; rw = 1; se = 1; end
      "andi", "ori", "xori": begin aSrc = 1; rw = 1; end
      "lw", "lh": begin aSrc = 1; rw = 1; m2r = 1; se = 1; hw = (m == "lh"); end
      "sw":       begin aSrc = 1; mw = 1; se = 1; end
      "beq":      begin bq = 1; se = 1; end
      "bne":      begin bn = 1; se = 1; end
      "blez":     begin bl = 1; se = 1; end
      "j":        jp = 1;
      "jal":      begin jp = 1; jl = 1; rw = 1; end
      "jr":       jreg = 1;
      "syscall":  sc = 1;
      default:    il = 1;
    endcase
    return {alu, aSrc, rw, m2r, mw, rd, se, hw, vs, bq, bn, bl, jp, jl, jreg, sc, il};
  endfunction

  // Reference model: halt progress is tracked as the edge number at which the halting
  // SYSCALL was accepted, rather than as a state machine.
  int          edgeCnt    = 0;
  int          haltEdge   = -1;
  int          mDec       = 0;
  int          mBub       = 0;
  logic [19:0] mBundle    = '0;
  logic        mValid     = 1'b0;
  bit          modelReady = 1'b0;
  bit          mRunning, mAcc;

  always @(posedge CLK) begin
    edgeCnt++;
    if (RST) begin
      mValid = 0; mBundle = '0; haltEdge = -1; mDec = 0; mBub = 0; modelReady = 1;
    end else if (modelReady) begin
      mRunning = (haltEdge < 0);
      mAcc = ID_Valid && !Stall && !Flush && mRunning;
      if (mAcc) begin
        mBundle = modelBundle(OP, Func);
        mValid  = 1;
        mDec++;
        if (mnemonic(OP, Func) == "syscall" && SysArgHalt) haltEdge = edgeCnt;
      end else begin
        mBundle = '0;
        mValid  = 0;
        if (mRunning) mBub++;
      end
    end
  end

  always @(negedge CLK) begin
    if (modelReady) begin
      checkOutput("EX_Valid", 32'(EX_Valid), 32'(mValid));
      checkOutput("bundle", 32'(dutVec), 32'(mBundle));
      checkOutput("FetchEn", 32'(FetchEn), 32'((haltEdge < 0) && !Stall));
      checkOutput("Halted", 32'(Halted), 32'((haltEdge >= 0) && (edgeCnt - haltEdge >= DRAIN)));
`ifdef CTRL_STATS_EN
      checkOutput("DecCnt", 32'(DecCnt), 32'(mDec % 16));
      checkOutput("BubbleCnt", 32'(BubbleCnt), 32'(mBub % 16));
`endif
    end
  end

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] fn,
                               input logic st, input logic fl, input logic sh);
    ID_Valid = v; OP = op; Func = fn; Stall = st; Flush = fl; SysArgHalt = sh;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    RST = 1'b1;
    idle();
    idle();
    RST = 1'b0;
  endtask

  logic [11:0] vecTable [20] = '{
    {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26},
    {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2B}, {6'h00, 6'h00}, {6'h00, 6'h02},
    {6'h00, 6'h07}, {6'h00, 6'h08}, {6'h00, 6'h01}, {6'h09, 6'h15}, {6'h0B, 6'h00},
    {6'h0E, 6'h3F}, {6'h21, 6'h00}, {6'h05, 6'h00}, {6'h06, 6'h00}, {6'h02, 6'h00}
  };

  initial begin
    RST = 1'b1; ID_Valid = 0; OP = 0; Func = 0; Stall = 0; Flush = 0; SysArgHalt = 0;
    resetDut();
    checkOutput("reset EX_Valid", 32'(EX_Valid), 32'd0);
    checkOutput("reset bundle", 32'(dutVec), 32'd0);
    checkOutput("reset FetchEn", 32'(FetchEn), 32'd1);
    checkOutput("reset Halted", 32'(Halted), 32'd0);

    applyStimulus(1, 6'h00, 6'h20, 0, 0, 0);
    checkOutput("add EX_Valid", 32'(EX_Valid), 32'd1);
    checkOutput("add bundle", 32'(dutVec), 32'h54800);

    resetDut();
    applyStimulus(1, 6'h23, 6'h00, 1, 0, 0);
    checkOutput("stall1 EX_Valid", 32'(EX_Valid), 32'd0);
    checkOutput("stall1 FetchEn", 32'(FetchEn), 32'd0);
    applyStimulus(1, 6'h23, 6'h00, 1, 0, 0);
    checkOutput("stall2 EX_Valid", 32'(EX_Valid), 32'd0);
    applyStimulus(1, 6'h23, 6'h00, 0, 0, 0);
    checkOutput("lw bundle", 32'(dutVec), 32'h5E400);
    checkOutput("lw FetchEn", 32'(FetchEn), 32'd1);
`ifdef CTRL_STATS_EN
    checkOutput("lw DecCnt", 32'(DecCnt), 32'd1);
    checkOutput("lw BubbleCnt", 32'(BubbleCnt), 32'd2);
`endif

    applyStimulus(1, 6'h04, 6'h00, 0, 1, 0);
    checkOutput("flush EX_Valid", 32'(EX_Valid), 32'd0);
    applyStimulus(1, 6'h04, 6'h00, 0, 0, 0);
    checkOutput("beq bundle", 32'(dutVec), 32'h60480);

    applyStimulus(1, 6'h00, 6'h0C, 0, 0, 0);
    checkOutput("syscall nohalt bundle", 32'(dutVec), 32'h2);
    applyStimulus(1, 6'h00, 6'h0C, 0, 1, 1);
    checkOutput("syscall flushed EX_Valid", 32'(EX_Valid), 32'd0);
    idle();
    checkOutput("syscall flushed FetchEn", 32'(FetchEn), 32'd1);
    checkOutput("syscall flushed Halted", 32'(Halted), 32'd0);

    applyStimulus(1, 6'h3F, 6'h00, 0, 0, 0);
    checkOutput("illegal EX_Valid", 32'(EX_Valid), 32'd1);
    checkOutput("illegal bundle", 32'(dutVec), 32'h1);
    applyStimulus(1, 6'h2B, 6'h00, 0, 0, 0);
    checkOutput("sw bundle", 32'(dutVec), 32'h59400);
    applyStimulus(1, 6'h00, 6'h03, 0, 0, 0);
    checkOutput("sra bundle", 32'(dutVec), 32'h14900);
    applyStimulus(1, 6'h03, 6'h00, 0, 0, 0);
    checkOutput("jal bundle", 32'(dutVec), 32'h04018);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, vecTable[i][11:6], vecTable[i][5:0], 0, 0, 0);
    end

    applyStimulus(1, 6'h00, 6'h0C, 0, 0, 1);
    checkOutput("halt syscall bundle", 32'(dutVec), 32'h2);
    checkOutput("halt N FetchEn", 32'(FetchEn), 32'd0);
    applyStimulus(1, 6'h00, 6'h20, 0, 0, 0);
    checkOutput("drain squash EX_Valid", 32'(EX_Valid), 32'd0);
    checkOutput("N+1 Halted", 32'(Halted), 32'd0);
    idle();
    checkOutput("N+2 Halted", 32'(Halted), 32'd0);
    idle();
    checkOutput("N+3 Halted", 32'(Halted), 32'd1);
    applyStimulus(1, 6'h00, 6'h20, 0, 0, 0);
    applyStimulus(1, 6'h00, 6'h20, 0, 0, 0);
    checkOutput("halt sticky Halted", 32'(Halted), 32'd1);
    checkOutput("halt sticky EX_Valid", 32'(EX_Valid), 32'd0);
    RST = 1'b1;
    idle();
    RST = 1'b0;
    checkOutput("halt reset Halted", 32'(Halted), 32'd0);
    checkOutput("halt reset FetchEn", 32'(FetchEn), 32'd1);

    resetDut();
    repeat (17) applyStimulus(1, 6'h00, 6'h20, 0, 0, 0);
`ifdef CTRL_STATS_EN
    checkOutput("wrap DecCnt", 32'(DecCnt), 32'd1);
    checkOutput("wrap BubbleCnt", 32'(BubbleCnt), 32'd0);
`endif
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
